// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock with on-the-fly
// key expansion, valid/ready handshakes on both sides. Vectors are [0:127] with
// byte 0 in bits [0:7] and a column-major state (bytes 0-3 form column 0).
module aes_encrypt_iter #(
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam int unsigned KeyBits = 32 * Nk;
  localparam logic [3:0]  NrLast  = 4'(Nr);

  // Forward S-box, entry x at bits [8x +: 8].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e               r_fsm, w_fsm_next;
  logic [0:127]       r_state, w_state_next;
  logic [0:KeyBits-1] r_rk, w_rk_next;
  logic [3:0]         r_rnd, w_rnd_next;
  logic [0:127]       w_sr;
  logic [0:127]       w_rk_exp;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r of the column-major state rotates left by r bytes.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [0:127] key_expand(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[0 +: 32];
    w1 = k[32 +: 32];
    w2 = k[64 +: 32];
    w3 = k[96 +: 32];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w_sr     = shift_rows(sub_bytes(r_state));
  assign w_rk_exp = key_expand(r_rk, rcon(r_rnd));

  // Next-state: accept in idle, one round per cycle, hold result until taken.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_state_next = r_state;
    w_rk_next    = r_rk;
    w_rnd_next   = r_rnd;
    unique case (r_fsm)
      StIdle: begin
        if (in_valid) begin
          w_state_next = in_data ^ in_key;
          w_rk_next    = in_key;
          w_rnd_next   = 4'd1;
          w_fsm_next   = StRound;
        end
      end
      StRound: begin
        w_rk_next  = w_rk_exp;
        w_rnd_next = r_rnd + 4'd1;
        if (r_rnd == NrLast) begin
          // Final round skips MixColumns.
          w_state_next = w_sr ^ w_rk_exp;
          w_fsm_next   = StDone;
        end else begin
          w_state_next = mix_columns(w_sr) ^ w_rk_exp;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_fsm_next = StIdle;
        end
      end
      default: w_fsm_next = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_state <= w_state_next;
      r_rk    <= w_rk_next;
      r_rnd   <= w_rnd_next;
    end
  end

  assign in_ready  = rst_n && (r_fsm == StIdle);
  assign out_valid = (r_fsm == StDone);
  assign busy      = (r_fsm != StIdle);
  assign out_data  = out_valid ? r_state : '0;

endmodule
